// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the PC register, requests words from a
// variable-latency instruction memory and holds the result in a one-entry IF/ID slot.
//
// Handshakes: the IM access is a valid/ready pair where IMReq is valid and IMAck is
// ready; a word transfers only in a cycle where both are 1. The IF/ID slot is a
// valid/ready pair where InstrValid is valid and ~DecStall is ready; the slot is
// consumed at an edge where both are 1.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h3000,
    parameter logic [31:0] EXC_PC   = 32'h4180,
    parameter int          TIMEOUT  = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] PC,
    output logic [31:0] NPC,
    output logic        Stall,
    output logic        IMReq,
    output logic [9:0]  IMaddr,
    input  logic        IMAck,
    input  logic [31:0] IMData,
    input  logic        DecStall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        ExcReq,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    output logic        FetchErr,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    // The external PC register resets to RESET_PC, so it must be a word address.
    if (RESET_PC[1:0] != 2'b00 || TIMEOUT < 2) begin : g_param_check
        $error("fetch_ctrl: RESET_PC must be word aligned and TIMEOUT >= 2");
    end

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          flush;
    logic          ack_take;
    logic          slot_consumed;

    assign dbg_state     = state;
    assign IMaddr        = PC[11:2];
    assign flush         = ExcReq | RedirectValid;
    assign slot_consumed = InstrValid & ~DecStall;

    always_comb begin
        IMReq    = (state == ST_REQ) & ~(InstrValid & DecStall);
        ack_take = IMReq & IMAck & ~flush;
        Stall    = 1'b1;
        NPC      = PC + 32'd4;
        if (ExcReq) begin
            Stall = 1'b0;
            NPC   = EXC_PC;
        end else if (RedirectValid) begin
            Stall = 1'b0;
            NPC   = RedirectTarget;
        end else if (ack_take) begin
            Stall = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            Instr      <= '0;
            InstrPC    <= '0;
            InstrValid <= 1'b0;
            FetchErr   <= 1'b0;
        end else if (flush) begin
            state      <= ST_REQ;
            wait_cnt   <= '0;
            InstrValid <= 1'b0;
            FetchErr   <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                state <= ST_REQ;
            end
            if (ack_take) begin
                Instr      <= IMData;
                InstrPC    <= PC;
                InstrValid <= 1'b1;
                wait_cnt   <= '0;
            end else begin
                if (slot_consumed) begin
                    InstrValid <= 1'b0;
                end
                // Back-pressure drops IMReq and abandons the access, so the wait restarts.
                if (IMReq) begin
                    if (wait_cnt == CNT_MAX) begin
                        state    <= ST_ERR;
                        FetchErr <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end else begin
                    wait_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences and a
// randomized run against a rule-level reference model. Owns the external PC register.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h3000;
    localparam logic [31:0] EXC_PC   = 32'h4180;
    localparam int          TIMEOUT  = 8;

    logic        CLK;
    logic        Reset;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        Stall;
    logic        IMReq;
    logic [9:0]  IMaddr;
    logic        IMAck;
    logic [31:0] IMData;
    logic        DecStall;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        ExcReq;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        FetchErr;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .Reset(Reset), .PC(PC), .NPC(NPC), .Stall(Stall), .IMReq(IMReq),
        .IMaddr(IMaddr), .IMAck(IMAck), .IMData(IMData), .DecStall(DecStall),
        .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget), .ExcReq(ExcReq),
        .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid), .FetchErr(FetchErr),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / PC register ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) PC <= RESET_PC;
        else if (!Stall) PC <= NPC;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic exc, input logic red, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] data, input logic dec);
        ExcReq = exc; RedirectValid = red; RedirectTarget = tgt;
        IMAck = ack; IMData = data; DecStall = dec;
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        exc;
        logic        red;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        dec;
        logic        e_req;
        logic        e_stall;
        logic [31:0] e_npc;
        logic [9:0]  e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_err;
    } vec_t;

    vec_t vecs[12];

    // ---------------- reference model ----------------
    bit          m_started;
    bit          m_err;
    int          m_wait;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    function automatic bit m_req(input logic dec);
        return m_started && !m_err && !(m_valid && dec);
    endfunction

    task automatic model_reset();
        m_started = 0; m_err = 0; m_wait = 0; m_valid = 0; m_instr = '0; m_ipc = '0;
    endtask

    task automatic model_step(input logic exc, input logic red, input logic ack,
                              input logic [31:0] data, input logic dec, input logic [31:0] pc);
        bit req;
        req = m_req(dec);
        if (exc || red) begin
            m_started = 1; m_err = 0; m_wait = 0; m_valid = 0;
        end else if (req && ack) begin
            m_started = 1; m_valid = 1; m_instr = data; m_ipc = pc; m_wait = 0;
        end else begin
            m_started = 1;
            if (m_valid && !dec) m_valid = 0;
            if (req) begin
                m_wait++;
                if (m_wait >= TIMEOUT) begin
                    m_err = 1;
                    m_wait = 0;
                end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_npc;
        logic        r_exc, r_red, r_ack, r_dec;
        logic [31:0] r_tgt, r_data;

        vecs[0]  = '{0, 0, 32'h0,    0, 32'h0,        0, 0, 1, 32'h3004, 10'h000, 0, 32'h0,        32'h0,    0};
        vecs[1]  = '{0, 0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h3004, 10'h000, 0, 32'h0,        32'h0,    0};
        vecs[2]  = '{0, 0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h3004, 10'h000, 0, 32'h0,        32'h0,    0};
        vecs[3]  = '{0, 0, 32'h0,    1, 32'h24080005, 0, 1, 0, 32'h3004, 10'h000, 0, 32'h0,        32'h0,    0};
        vecs[4]  = '{0, 0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h3008, 10'h001, 1, 32'h24080005, 32'h3000, 0};
        vecs[5]  = '{0, 0, 32'h0,    1, 32'h11111111, 0, 1, 0, 32'h3008, 10'h001, 0, 32'h24080005, 32'h3000, 0};
        vecs[6]  = '{0, 1, 32'h3100, 1, 32'h22222222, 0, 1, 0, 32'h3100, 10'h002, 1, 32'h11111111, 32'h3004, 0};
        vecs[7]  = '{0, 0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h3104, 10'h040, 0, 32'h11111111, 32'h3004, 0};
        vecs[8]  = '{1, 1, 32'h3200, 0, 32'h0,        0, 1, 0, 32'h4180, 10'h040, 0, 32'h11111111, 32'h3004, 0};
        vecs[9]  = '{0, 0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h4184, 10'h060, 0, 32'h11111111, 32'h3004, 0};
        vecs[10] = '{0, 0, 32'h0,    1, 32'h33333333, 0, 1, 0, 32'h4184, 10'h060, 0, 32'h11111111, 32'h3004, 0};
        vecs[11] = '{0, 0, 32'h0,    0, 32'h0,        1, 0, 1, 32'h4188, 10'h061, 1, 32'h33333333, 32'h4180, 0};

        Reset = 1'b1;
        drv(0, 0, 32'h0, 0, 32'h0, 0);
        repeat (2) cyc();
        chk("rst_imreq", IMReq, 0);
        chk("rst_stall", Stall, 1);
        chk("rst_npc", NPC, 32'h3004);
        chk("rst_valid", InstrValid, 0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_ipc", InstrPC, 32'h0);
        chk("rst_err", FetchErr, 0);
        Reset = 1'b0;

        // Directed table: row 0 runs in the cycle where reset is released.
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc();
            drv(vecs[i].exc, vecs[i].red, vecs[i].tgt, vecs[i].ack, vecs[i].data, vecs[i].dec);
            chk($sformatf("vec%0d_imreq", i), IMReq, vecs[i].e_req);
            chk($sformatf("vec%0d_stall", i), Stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_npc", i), NPC, vecs[i].e_npc);
            chk($sformatf("vec%0d_imaddr", i), IMaddr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), InstrValid, vecs[i].e_valid);
            chk($sformatf("vec%0d_instr", i), Instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_ipc", i), InstrPC, vecs[i].e_ipc);
            chk($sformatf("vec%0d_err", i), FetchErr, vecs[i].e_err);
        end

        // Decode back-pressure for 3 more cycles, then release.
        for (int i = 0; i < 3; i++) begin
            cyc();
            drv(0, 0, 32'h0, 0, 32'h0, 1);
            chk("bp_imreq", IMReq, 0);
            chk("bp_stall", Stall, 1);
            chk("bp_valid", InstrValid, 1);
            chk("bp_instr", Instr, 32'h33333333);
        end
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 0);
        chk("bp_release_imreq", IMReq, 1);

        // Redirect to the top word, then NPC wraps to 0.
        cyc();
        drv(0, 1, 32'hFFFFFFFC, 0, 32'h0, 0);
        chk("wrap_redir_npc", NPC, 32'hFFFFFFFC);
        chk("wrap_redir_stall", Stall, 0);

        // Eight unacknowledged request cycles lead to ERR.
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc();
            drv(0, 0, 32'h0, 0, 32'h0, 0);
            if (i == 0) begin
                chk("wrap_npc", NPC, 32'h0);
                chk("wrap_imaddr", IMaddr, 10'h3FF);
            end
            chk("to_wait_imreq", IMReq, 1);
            chk("to_wait_err", FetchErr, 0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            drv(0, 0, 32'h0, 0, 32'h0, 0);
            chk("err_flag", FetchErr, 1);
            chk("err_imreq", IMReq, 0);
            chk("err_stall", Stall, 1);
        end
        cyc();
        drv(1, 0, 32'h0, 0, 32'h0, 0);
        chk("err_exc_npc", NPC, EXC_PC);
        chk("err_exc_stall", Stall, 0);
        cyc();
        drv(0, 0, 32'h0, 1, 32'h55555555, 0);
        chk("err_exit_flag", FetchErr, 0);
        chk("err_exit_imreq", IMReq, 1);
        chk("err_exit_imaddr", IMaddr, 10'h060);

        // Asynchronous reset in the middle of a cycle with a valid slot.
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        chk("areset_pre_valid", InstrValid, 1);
        chk("areset_pre_instr", Instr, 32'h55555555);
        #1 Reset = 1'b1;
        #1;
        chk("areset_valid", InstrValid, 0);
        chk("areset_imreq", IMReq, 0);
        chk("areset_err", FetchErr, 0);
        chk("areset_instr", Instr, 32'h0);
        chk("areset_stall", Stall, 1);

        // Randomized run against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (c == 0) Reset = 1'b0;
            r_exc  = ($urandom_range(0, 39) == 0);
            r_red  = ($urandom_range(0, 19) == 0);
            r_tgt  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            r_dec  = ($urandom_range(0, 2) == 0);
            r_ack  = m_req(r_dec) && ($urandom_range(0, 2) == 0);
            r_data = $urandom;
            drv(r_exc, r_red, r_tgt, r_ack, r_data, r_dec);
            exp_npc = r_exc ? EXC_PC : (r_red ? r_tgt : PC + 32'd4);
            chk("rnd_imreq", IMReq, m_req(r_dec));
            chk("rnd_stall", Stall, !(r_exc || r_red || (m_req(r_dec) && r_ack)));
            chk("rnd_npc", NPC, exp_npc);
            chk("rnd_imaddr", IMaddr, PC[11:2]);
            chk("rnd_valid", InstrValid, m_valid);
            chk("rnd_err", FetchErr, m_err);
            if (m_valid) begin
                chk("rnd_instr", Instr, m_instr);
                chk("rnd_ipc", InstrPC, m_ipc);
            end
            model_step(r_exc, r_red, r_ack, r_data, r_dec, PC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
